// File: rtl/spi_slave_fifo.sv
// SPI target with clk-domain oversampling, multi-word framing and a show-ahead receive FIFO.
// Define SPI_SLAVE_TX_EN to build the full-duplex transmit shifter; otherwise sdo and tx_ready are tied low.
module spi_slave_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int MODE  = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sck,
  input  logic                       sdi,
  input  logic                       ce,
  output logic                       sdo,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       frame_err,
  input  logic                       clear_err,
  input  logic [WIDTH-1:0]           tx_data,
  input  logic                       tx_valid,
  output logic                       tx_ready
);

  localparam int   AW   = $clog2(DEPTH);
  localparam int   CNTW = AW + 1;
  localparam int   BW   = $clog2(WIDTH);
  localparam logic CPOL = ((MODE / 2) % 2) == 1;
  localparam logic CPHA = (MODE % 2) == 1;

  logic [2:0]       sck_s;
  logic [1:0]       sdi_s;
  logic [2:0]       ce_s;
  logic [1:0]       warm;
  logic             idle_seen;
  logic             in_frame;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] rx_shift;
  logic [WIDTH-1:0] push_word;
  logic             push_pending;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_s <= {3{CPOL}};
      sdi_s <= '0;
      ce_s  <= '0;
    end else begin
      sck_s <= {sck_s[1:0], sck};
      sdi_s <= {sdi_s[0], sdi};
      ce_s  <= {ce_s[1:0], ce};
    end
  end

  logic sck_edge, lead_edge, trail_edge, sample_edge, shift_edge;
  logic ce_rise, ce_fall, frame_start, active, word_done;

  assign sck_edge    = sck_s[1] ^ sck_s[2];
  assign lead_edge   = sck_edge && (sck_s[1] != CPOL);
  assign trail_edge  = sck_edge && (sck_s[1] == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign ce_rise     = ce_s[1] & ~ce_s[2];
  assign ce_fall     = ~ce_s[1] & ce_s[2];
  assign frame_start = ce_rise && idle_seen;
  assign active      = in_frame && ce_s[1];
  assign word_done   = active && sample_edge && (bit_cnt == BW'(WIDTH - 1));

  // A frame only starts from a ce rise seen after ce was genuinely low post-reset,
  // so a ce held high through reset cannot resume the abandoned frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      warm      <= '0;
      idle_seen <= 1'b0;
    end else begin
      if (warm != 2'd3) warm <= warm + 2'd1;
      idle_seen <= idle_seen | (warm[1] & ~ce_s[1]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_frame     <= 1'b0;
      bit_cnt      <= '0;
      rx_shift     <= '0;
      push_word    <= '0;
      push_pending <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      push_pending <= 1'b0;
      if (clear_err) frame_err <= 1'b0;
      if (frame_start) begin
        in_frame <= 1'b1;
        bit_cnt  <= '0;
      end else if (in_frame && ce_fall) begin
        in_frame <= 1'b0;
        bit_cnt  <= '0;
        if (bit_cnt != '0) frame_err <= 1'b1;
      end else if (active && sample_edge) begin
        rx_shift <= {rx_shift[WIDTH-2:0], sdi_s[1]};
        if (word_done) begin
          bit_cnt      <= '0;
          push_pending <= 1'b1;
          push_word    <= {rx_shift[WIDTH-2:0], sdi_s[1]};
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  logic full, do_push, do_pop, drop;
  assign empty   = (count == '0);
  assign full    = (count == CNTW'(DEPTH));
  assign do_pop  = rd_en && !empty;
  assign do_push = push_pending && (!full || do_pop);
  assign drop    = push_pending && full && !do_pop;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (clear_err) overflow <= 1'b0;
      if (drop) overflow <= 1'b1;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef SPI_SLAVE_TX_EN
  logic [WIDTH-1:0] tx_shift;
  logic             skip_shift;
  logic             tx_load;
  assign tx_load = frame_start || word_done;

  // With CPHA=1 the leading edge right after a load would otherwise discard the MSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_shift   <= '0;
      skip_shift <= 1'b0;
      tx_ready   <= 1'b0;
    end else begin
      tx_ready <= 1'b0;
      if (tx_load) begin
        tx_shift   <= tx_valid ? tx_data : '0;
        tx_ready   <= tx_valid;
        skip_shift <= CPHA;
      end else if (active && shift_edge) begin
        if (skip_shift) skip_shift <= 1'b0;
        else            tx_shift   <= tx_shift << 1;
      end
    end
  end

  assign sdo = tx_shift[WIDTH-1];
`else
  logic unused_tx;
  assign unused_tx = ^{tx_data, tx_valid, shift_edge};
  assign sdo       = 1'b0;
  assign tx_ready  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_fifo.sv
// Directed bench for spi_slave_fifo: one MODE 0 and one MODE 3 instance sharing ce/sdi,
// expected receive words tracked in per-instance scoreboards.
module tb_spi_slave_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sck0 = 1'b0;
  logic       sck3 = 1'b1;
  logic       sdi = 1'b0;
  logic       ce = 1'b0;
  logic       rd_en0 = 1'b0;
  logic       rd_en3 = 1'b0;
  logic       clear_err = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data0 = 8'h00;
  logic       tx_valid0 = 1'b0;

  logic       sdo0, sdo3, empty0, empty3, overflow0, overflow3;
  logic       frame_err0, frame_err3, tx_ready0, tx_ready3;
  logic [7:0] rd_data0, rd_data3;
  logic [2:0] count0, count3;

  int passed = 0;
  int total = 0;
  int tx_pulses = 0;
  logic [7:0] q0[$];
  logic [7:0] q3[$];

  always #5 clk = ~clk;

  always @(posedge clk) if (tx_ready3) tx_pulses++;

  spi_slave_fifo #(.WIDTH(8), .DEPTH(4), .MODE(0)) dut0 (
    .clk(clk), .reset(reset), .sck(sck0), .sdi(sdi), .ce(ce), .sdo(sdo0),
    .rd_en(rd_en0), .rd_data(rd_data0), .empty(empty0), .count(count0),
    .overflow(overflow0), .frame_err(frame_err0), .clear_err(clear_err),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0)
  );

  spi_slave_fifo #(.WIDTH(8), .DEPTH(4), .MODE(3)) dut3 (
    .clk(clk), .reset(reset), .sck(sck3), .sdi(sdi), .ce(ce), .sdo(sdo3),
    .rd_en(rd_en3), .rd_data(rd_data3), .empty(empty3), .count(count3),
    .overflow(overflow3), .frame_err(frame_err3), .clear_err(clear_err),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready3)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One SPI word (or the first nbits of it) from the master; miso is what the master sampled.
  task automatic applyStimulus(input bit sel3, input logic [7:0] word, input int nbits,
                               input bit pop_last, output logic [7:0] miso);
    miso = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (!sel3) begin
        sdi = word[7-i];
        repeat (8) @(negedge clk);
        miso = {miso[6:0], sdo0};
        sck0 = 1'b1;
        if (pop_last && i == nbits - 1) begin
          repeat (3) @(negedge clk);
          rd_en0 = 1'b1;
          @(negedge clk);
          rd_en0 = 1'b0;
          repeat (4) @(negedge clk);
        end else begin
          repeat (8) @(negedge clk);
        end
        sck0 = 1'b0;
      end else begin
        sck3 = 1'b0;
        sdi  = word[7-i];
        repeat (8) @(negedge clk);
        miso = {miso[6:0], sdo3};
        sck3 = 1'b1;
        repeat (8) @(negedge clk);
      end
    end
  endtask

  task automatic frameBegin();
    ce = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic frameEnd();
    repeat (8) @(negedge clk);
    ce = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic sendWord0(input logic [7:0] word, input bit stored);
    logic [7:0] m;
    applyStimulus(1'b0, word, 8, 1'b0, m);
    if (stored) q0.push_back(word);
  endtask

  task automatic readWord(input bit sel3);
    logic [7:0] exp;
    exp = sel3 ? q3.pop_front() : q0.pop_front();
    @(negedge clk);
    checkOutput(sel3 ? "rd_data3" : "rd_data0", sel3 ? rd_data3 : rd_data0, exp);
    if (sel3) rd_en3 = 1'b1;
    else      rd_en0 = 1'b1;
    @(negedge clk);
    rd_en0 = 1'b0;
    rd_en3 = 1'b0;
  endtask

  task automatic pulseClear();
    @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] m;
    logic [7:0] exp_a, exp_b;

    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_empty", empty0, 1'b1);
    checkOutput("rst_count", count0, 3'd0);
    checkOutput("rst_overflow", overflow0, 1'b0);
    checkOutput("rst_frame_err", frame_err0, 1'b0);
    checkOutput("rst_rd_data", rd_data0, 8'h00);
    checkOutput("rst_sdo", sdo3, 1'b0);
    checkOutput("rst_tx_ready", tx_ready3, 1'b0);
    repeat (5) @(negedge clk);

    $display("[TB] two-word frame, mode 0");
    frameBegin();
    sendWord0(8'hA5, 1'b1);
    sendWord0(8'h3C, 1'b1);
    frameEnd();
    checkOutput("two_count", count0, 3'd2);
    checkOutput("two_overflow", overflow0, 1'b0);
    checkOutput("two_frame_err", frame_err0, 1'b0);
    readWord(1'b0);
    readWord(1'b0);
    checkOutput("two_empty", empty0, 1'b1);

    $display("[TB] overflow with five words");
    frameBegin();
    sendWord0(8'h11, 1'b1);
    sendWord0(8'h22, 1'b1);
    sendWord0(8'h33, 1'b1);
    sendWord0(8'h44, 1'b1);
    sendWord0(8'h55, 1'b0);
    frameEnd();
    checkOutput("ovf_count", count0, 3'd4);
    checkOutput("ovf_flag", overflow0, 1'b1);
    pulseClear();
    checkOutput("ovf_cleared", overflow0, 1'b0);
    for (int i = 0; i < 4; i++) readWord(1'b0);
    checkOutput("ovf_empty", empty0, 1'b1);

    $display("[TB] push and pop while full");
    frameBegin();
    sendWord0(8'h81, 1'b1);
    sendWord0(8'h82, 1'b1);
    sendWord0(8'h83, 1'b1);
    sendWord0(8'h84, 1'b1);
    checkOutput("full_head", rd_data0, q0[0]);
    applyStimulus(1'b0, 8'h85, 8, 1'b1, m);
    void'(q0.pop_front());
    q0.push_back(8'h85);
    frameEnd();
    checkOutput("full_count", count0, 3'd4);
    checkOutput("full_overflow", overflow0, 1'b0);
    for (int i = 0; i < 4; i++) readWord(1'b0);

    $display("[TB] ce drop mid-word");
    frameBegin();
    applyStimulus(1'b0, 8'hFF, 5, 1'b0, m);
    frameEnd();
    checkOutput("ferr_flag", frame_err0, 1'b1);
    checkOutput("ferr_count", count0, 3'd0);
    pulseClear();
    checkOutput("ferr_cleared", frame_err0, 1'b0);
    frameBegin();
    sendWord0(8'h55, 1'b1);
    frameEnd();
    checkOutput("ferr_next_count", count0, 3'd1);
    readWord(1'b0);

    $display("[TB] mode 3 full duplex");
    tx_data  = 8'h96;
    tx_valid = 1'b1;
    frameBegin();
    tx_data = 8'h0F;
    applyStimulus(1'b1, 8'h12, 8, 1'b0, m);
    tx_valid = 1'b0;
`ifdef SPI_SLAVE_TX_EN
    exp_a = 8'h96;
    exp_b = 8'h0F;
`else
    exp_a = 8'h00;
    exp_b = 8'h00;
`endif
    checkOutput("miso_w0", m, exp_a);
    applyStimulus(1'b1, 8'h34, 8, 1'b0, m);
    checkOutput("miso_w1", m, exp_b);
    applyStimulus(1'b1, 8'h56, 8, 1'b0, m);
    checkOutput("miso_idle", m, 8'h00);
    frameEnd();
`ifdef SPI_SLAVE_TX_EN
    checkOutput("tx_pulses", tx_pulses, 2);
`else
    checkOutput("tx_pulses", tx_pulses, 0);
`endif
    q3.push_back(8'h12);
    q3.push_back(8'h34);
    q3.push_back(8'h56);
    checkOutput("m3_count", count3, 3'd3);
    for (int i = 0; i < 3; i++) readWord(1'b1);
    checkOutput("m0_untouched", count0, 3'd0);

    $display("[TB] reset mid-word");
    frameBegin();
    sendWord0(8'h01, 1'b1);
    sendWord0(8'h02, 1'b1);
    frameEnd();
    checkOutput("pre_rst_count", count0, 3'd2);
    frameBegin();
    applyStimulus(1'b0, 8'hFF, 3, 1'b0, m);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    q0.delete();
    checkOutput("mid_rst_empty", empty0, 1'b1);
    checkOutput("mid_rst_count", count0, 3'd0);
    frameEnd();
    checkOutput("mid_rst_frame_err", frame_err0, 1'b0);
    frameBegin();
    sendWord0(8'hC3, 1'b1);
    frameEnd();
    checkOutput("post_rst_count", count0, 3'd1);
    readWord(1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
